// File: rtl/truth_table_sweeper_if.sv
// Sweeper handshake and result bundle.
// Master drives start/abort/dut_out; the sweeper is the slave.
interface truth_table_sweeper_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic            abort;
   logic            dut_out;
   logic [N_IN-1:0] dut_in;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic            fail_valid;
   logic [N_IN-1:0] fail_vec;

   modport master (
      output start, abort, dut_out,
      input  dut_in, busy, done, pass,
      input  err_count, fail_valid, fail_vec
   );

   modport slave (
      input  start, abort, dut_out,
      output dut_in, busy, done, pass,
      output err_count, fail_valid, fail_vec
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table checker for a small combinational DUT.
// Holds each input vector HOLD cycles, samples on the last one.
module truth_table_sweeper #(
   parameter int                 N_IN     = 2,
   parameter int                 HOLD     = 10,
   parameter logic [2**N_IN-1:0] EXPECTED = 4'b1000
) (
   input logic                  clk,
   input logic                  rst_n,
   truth_table_sweeper_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      DONE
   } state_t;

   localparam logic [N_IN-1:0] LAST_VEC  = '1;
   localparam logic [7:0]      HOLD_LAST = 8'(HOLD - 1);

   state_t          state;
   logic [7:0]      hold_cnt;
   logic [N_IN-1:0] vec;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic [N_IN:0]   err_q;
   logic            fv_q;
   logic [N_IN-1:0] fvec_q;
   logic            mismatch;

   assign mismatch = bus.dut_out != EXPECTED[vec];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
         vec      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         fv_q     <= 1'b0;
         fvec_q   <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               // start beats a simultaneous abort here
               if (bus.start) begin
                  state    <= DRIVE;
                  hold_cnt <= '0;
                  vec      <= '0;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
                  pass_q   <= 1'b0;
                  err_q    <= '0;
                  fv_q     <= 1'b0;
                  fvec_q   <= '0;
               end
            end
            DRIVE: begin
               if (bus.abort) begin
                  state    <= IDLE;
                  hold_cnt <= '0;
                  vec      <= '0;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b0;
                  pass_q   <= 1'b0;
               end else if (hold_cnt == HOLD_LAST) begin
                  hold_cnt <= '0;
                  if (mismatch) begin
                     err_q <= err_q + 1'b1;
                     if (!fv_q) begin
                        fv_q   <= 1'b1;
                        fvec_q <= vec;
                     end
                  end
                  if (vec == LAST_VEC) begin
                     state  <= DONE;
                     vec    <= '0;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     pass_q <= (err_q == '0) && !mismatch;
                  end else begin
                     vec <= vec + 1'b1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dut_in     = vec;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.err_count  = err_q;
   assign bus.fail_valid = fv_q;
   assign bus.fail_vec   = fvec_q;
endmodule
